// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared VGA 640x480@60 timing constants, pixel format and the
//           capture FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_HPIXELS  = 800;
   localparam int VGA_HPULSE   = 96;
   localparam int VGA_HBP      = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_VLINES   = 525;
   localparam int VGA_VPULSE   = 2;
   localparam int VGA_VBP      = 33;

   localparam int PIX_W = 12;
   localparam int CNT_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } cap_state_t;

   function automatic logic [PIX_W-1:0] pack_rgb(input logic [3:0] r,
                                                  input logic [3:0] g,
                                                  input logic [3:0] b);
      return {r, g, b};
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_tracker.sv
// ============================================================================
// Module  : vga_sync_tracker
// Purpose : Registers the incoming VGA stream, finds sync leading edges and
//           tracks the pixel position and line-length lock of each sample.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_tracker
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int HPIXELS     = VGA_HPIXELS,
   parameter int HPULSE      = VGA_HPULSE,
   parameter int HBP         = VGA_HBP,
   parameter int VPULSE      = VGA_VPULSE,
   parameter int VBP         = VGA_VBP,
   parameter bit SYNC_ACTIVE = 1'b1
) (
   input  logic             Xclk,
   input  logic             rst,
   input  logic             hsync_i,
   input  logic             vsync_i,
   input  logic [PIX_W-1:0] rgb_i,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             active,
   output logic             locked,
   output logic             vsync_edge,
   output logic [PIX_W-1:0] pix
);

   localparam logic [CNT_W-1:0] HC_LAST  = CNT_W'(HPIXELS - 1);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(HPULSE + HBP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HPULSE + HBP + H_ACTIVE);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(VPULSE + VBP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VPULSE + VBP + V_ACTIVE);

   logic             hs_q, hs_d, vs_q, vs_d;
   logic [PIX_W-1:0] rgb_q, rgb_d;
   logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
   logic             vedge_q, vedge_d;
   logic             match_q, match_d;
   logic             locked_q, locked_d;
   logic             hs_lead, vs_lead;

   // Edges are found one sample early so hc/vc describe the sample now in rgb_q.
   always_comb begin
      hs_lead  = (hsync_i == SYNC_ACTIVE) && (hs_q != SYNC_ACTIVE);
      vs_lead  = (vsync_i == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);
      hs_d     = hsync_i;
      vs_d     = vsync_i;
      rgb_d    = rgb_i;
      vedge_d  = vs_lead;
      hc_d     = (hc_q == '1) ? hc_q : hc_q + CNT_W'(1);
      vc_d     = vc_q;
      match_d  = match_q;
      locked_d = locked_q;
      if (hs_lead) begin
         hc_d = '0;
         vc_d = (vc_q == '1) ? vc_q : vc_q + CNT_W'(1);
         if (hc_q == HC_LAST) begin
            match_d  = 1'b1;
            locked_d = match_q;
         end else begin
            match_d  = 1'b0;
            locked_d = 1'b0;
         end
      end
      if (vs_lead) begin
         vc_d = '0;
      end
   end

   always_ff @(posedge Xclk or posedge rst) begin
      if (rst) begin
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         rgb_q    <= '0;
         hc_q     <= '0;
         vc_q     <= '0;
         vedge_q  <= 1'b0;
         match_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         rgb_q    <= rgb_d;
         hc_q     <= hc_d;
         vc_q     <= vc_d;
         vedge_q  <= vedge_d;
         match_q  <= match_d;
         locked_q <= locked_d;
      end
   end

   assign x          = hc_q - HS_START;
   assign y          = vc_q - VS_START;
   assign active     = (hc_q >= HS_START) && (hc_q < HS_END) &&
                       (vc_q >= VS_START) && (vc_q < VS_END);
   assign locked     = locked_q;
   assign vsync_edge = vedge_q;
   assign pix        = rgb_q;

endmodule

`default_nettype wire

// File: rtl/vga_capture.sv
// ============================================================================
// Module  : vga_capture
// Purpose : Software-armed single-frame VGA capture into frame RAM.
//           VGA_CAPTURE_DECIMATE_EN selects 2x2 decimated (320x240) capture.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_capture
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int HPIXELS     = VGA_HPIXELS,
   parameter int HPULSE      = VGA_HPULSE,
   parameter int HBP         = VGA_HBP,
   parameter int VPULSE      = VGA_VPULSE,
   parameter int VBP         = VGA_VBP,
   parameter bit SYNC_ACTIVE = 1'b1,
   parameter int ADDR_W      = 19
) (
   input  logic              Xclk,
   input  logic              rst,
   input  logic              cap_start,
   input  logic              hsync_i,
   input  logic              vsync_i,
   input  logic [3:0]        red_i,
   input  logic [3:0]        green_i,
   input  logic [3:0]        blue_i,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_adr,
   output logic [PIX_W-1:0]  wr_dat,
   output logic              busy,
   output logic              frame_done,
   output logic              locked,
   output logic              err
);

   logic [CNT_W-1:0] trk_x, trk_y;
   logic             trk_active, trk_locked, trk_vedge;
   logic [PIX_W-1:0] trk_pix;
   logic             take_pix, last_pix;

   vga_sync_tracker #(
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .HPIXELS     (HPIXELS),
      .HPULSE      (HPULSE),
      .HBP         (HBP),
      .VPULSE      (VPULSE),
      .VBP         (VBP),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_sync (
      .Xclk       (Xclk),
      .rst        (rst),
      .hsync_i    (hsync_i),
      .vsync_i    (vsync_i),
      .rgb_i      (pack_rgb(red_i, green_i, blue_i)),
      .x          (trk_x),
      .y          (trk_y),
      .active     (trk_active),
      .locked     (trk_locked),
      .vsync_edge (trk_vedge),
      .pix        (trk_pix)
   );

`ifdef VGA_CAPTURE_DECIMATE_EN
   localparam logic [CNT_W-1:0] LAST_X = CNT_W'(H_ACTIVE - 2);
   localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(V_ACTIVE - 2);
   assign take_pix = trk_active && !trk_x[0] && !trk_y[0];
`else
   localparam logic [CNT_W-1:0] LAST_X = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(V_ACTIVE - 1);
   assign take_pix = trk_active;
`endif
   assign last_pix = (trk_x == LAST_X) && (trk_y == LAST_Y);

   cap_state_t        state_q, state_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_adr_q, wr_adr_d;
   logic [ADDR_W-1:0] adr_cnt_q, adr_cnt_d;
   logic [PIX_W-1:0]  wr_dat_q, wr_dat_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      wr_adr_d  = wr_adr_q;
      adr_cnt_d = adr_cnt_q;
      wr_dat_d  = wr_dat_q;
      done_d    = 1'b0;
      err_d     = err_q;
      busy_d    = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            wr_adr_d  = '0;
            adr_cnt_d = '0;
            if (cap_start) begin
               state_d = ST_ARMED;
               err_d   = 1'b0;
            end
         end
         ST_ARMED: begin
            if (trk_vedge && trk_locked) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // A lost lock or an early frame start means the frame is torn.
            if (!trk_locked || trk_vedge) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (take_pix) begin
               wr_en_d   = 1'b1;
               wr_dat_d  = trk_pix;
               wr_adr_d  = adr_cnt_q;
               adr_cnt_d = adr_cnt_q + ADDR_W'(1);
               if (last_pix) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Xclk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_en_q   <= 1'b0;
         wr_adr_q  <= '0;
         adr_cnt_q <= '0;
         wr_dat_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         wr_adr_q  <= wr_adr_d;
         adr_cnt_q <= adr_cnt_d;
         wr_dat_q  <= wr_dat_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_adr     = wr_adr_q;
   assign wr_dat     = wr_dat_q;
   assign frame_done = done_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign locked     = trk_locked;

endmodule

`default_nettype wire

// File: tb/tb_vga_capture.sv
// ============================================================================
// Module  : tb_vga_capture
// Purpose : Directed bench for vga_capture on a shrunken raster (8x4 active,
//           16x8 total) so whole frames stay short.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_capture;

   localparam int TH  = 8;
   localparam int TV  = 4;
   localparam int THP = 16;
   localparam int THS = 2;
   localparam int THB = 2;
   localparam int TVS = 1;
   localparam int TVB = 1;
   localparam int TVL = 8;
   localparam int FRAME = THP * TVL;
`ifdef VGA_CAPTURE_DECIMATE_EN
   localparam int N_FULL  = (TH / 2) * (TV / 2);
   localparam int N_SHORT = TH / 2;
`else
   localparam int N_FULL  = TH * TV;
   localparam int N_SHORT = 2 * TH;
`endif

   logic        Xclk = 1'b0;
   logic        rst, cap_start, hsync_i, vsync_i;
   logic [3:0]  red_i, green_i, blue_i;
   logic        wr_en, busy, frame_done, locked, err;
   logic [18:0] wr_adr;
   logic [11:0] wr_dat;

   always #5 Xclk = ~Xclk;

   vga_capture #(
      .H_ACTIVE(TH), .V_ACTIVE(TV), .HPIXELS(THP), .HPULSE(THS), .HBP(THB),
      .VPULSE(TVS), .VBP(TVB), .SYNC_ACTIVE(1'b1), .ADDR_W(19)
   ) dut (
      .Xclk(Xclk), .rst(rst), .cap_start(cap_start), .hsync_i(hsync_i),
      .vsync_i(vsync_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
      .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat), .busy(busy),
      .frame_done(frame_done), .locked(locked), .err(err)
   );

   int total = 0;
   int bad   = 0;

   int gcol = 0, grow = 0, short_row = -1, cyc = 0;
   bit cap_req = 0, watch00 = 0;
   int nwr, last_adr, done_cnt, done_adr, done_wren, done_cyc;
   int busy_at_done, busy_after, data_bad, adr_bad, pix00_cyc, first_wr_cyc;

   typedef struct {
      int cap_row;
      int cap_col;
      int short_row;
      int exp_wr;
      int exp_last;
      int exp_done;
      int exp_err;
   } vec_t;
   vec_t vecs[3];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [11:0] exp_pix(input int a);
      int x, y;
`ifdef VGA_CAPTURE_DECIMATE_EN
      x = 2 * (a % (TH / 2));
      y = 2 * (a / (TH / 2));
`else
      x = a % TH;
      y = a / TH;
`endif
      return {x[3:0], y[3:0], 4'h5};
   endfunction

   task automatic clear_stats();
      nwr = 0; last_adr = -1; done_cnt = 0; done_adr = -1; done_wren = 0;
      done_cyc = -10; busy_at_done = -1; busy_after = -1; data_bad = 0;
      adr_bad = 0; pix00_cyc = -100; first_wr_cyc = -1;
   endtask

   // One pixel clock: observe last edge's outputs, then drive the next sample.
   task automatic gen_cycle();
      int x, y, len;
      @(negedge Xclk);
      if (wr_en) begin
         if (nwr == 0) first_wr_cyc = cyc;
         if (int'(wr_adr) != nwr) adr_bad++;
         if (wr_dat != exp_pix(int'(wr_adr))) data_bad++;
         last_adr = int'(wr_adr);
         nwr++;
      end
      if (frame_done) begin
         done_cnt++;
         done_adr = int'(wr_adr);
         done_wren = int'(wr_en);
         done_cyc = cyc;
         busy_at_done = int'(busy);
      end
      if (cyc == done_cyc + 1) busy_after = int'(busy);
      x = gcol - (THS + THB);
      y = grow - (TVS + TVB);
      hsync_i = (gcol < THS);
      vsync_i = (grow < TVS);
      if (x >= 0 && x < TH && y >= 0 && y < TV)
         {red_i, green_i, blue_i} = {x[3:0], y[3:0], 4'h5};
      else
         {red_i, green_i, blue_i} = 12'h000;
      if (watch00 && x == 0 && y == 0) begin
         pix00_cyc = cyc;
         watch00 = 0;
      end
      cap_start = cap_req;
      cap_req = 0;
      cyc++;
      len = (grow == short_row) ? THP - 1 : THP;
      gcol++;
      if (gcol >= len) begin
         if (grow == short_row) short_row = -1;
         gcol = 0;
         grow = (grow + 1) % TVL;
      end
   endtask

   task automatic wait_pos(input int r, input int c);
      int n = 0;
      while (!(grow == r && gcol == c) && n < 4 * FRAME) begin
         gen_cycle();
         n++;
      end
      if (!(grow == r && gcol == c)) begin
         total++;
         bad++;
         $display("FAIL wait_pos: got row %0d col %0d expected row %0d col %0d", grow, gcol, r, c);
      end
   endtask

   initial begin
      vecs[0] = '{3, 5, -1, N_FULL,  N_FULL - 1,  1, 0};
      vecs[1] = '{7, 0,  3, N_SHORT, N_SHORT - 1, 0, 1};
      vecs[2] = '{4, 9, -1, N_FULL,  N_FULL - 1,  1, 0};

      rst = 1; cap_start = 1; hsync_i = 0; vsync_i = 0;
      red_i = 0; green_i = 0; blue_i = 0;
      clear_stats();
      repeat (3) @(negedge Xclk);
      chk("reset_wr_en", wr_en, 0);
      chk("reset_wr_adr", wr_adr, 0);
      chk("reset_wr_dat", wr_dat, 0);
      chk("reset_flags", {busy, frame_done, locked, err}, 0);
      rst = 0; cap_start = 0;

      // Free-running source with no capture request.
      wait_pos(1, 8);
      chk("lock_one_match", locked, 0);
      chk("cap_with_rst_ignored", busy, 0);
      wait_pos(2, 8);
      chk("lock_third_line", locked, 1);
      clear_stats();
      repeat (3 * FRAME) gen_cycle();
      chk("idle_writes", nwr, 0);
      chk("idle_err", err, 0);
      chk("idle_locked", locked, 1);

      for (int i = 0; i < 3; i++) begin
         wait_pos(vecs[i].cap_row, vecs[i].cap_col);
         clear_stats();
         cap_req = 1;
         watch00 = 1;
         gen_cycle();
         if (vecs[i].short_row >= 0) short_row = vecs[i].short_row;
         repeat (3) gen_cycle();
         chk($sformatf("v%0d_err_clear", i), err, 0);
         chk($sformatf("v%0d_busy_armed", i), busy, 1);
         repeat (2 * FRAME + 16) gen_cycle();
         chk($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
         chk($sformatf("v%0d_last_adr", i), last_adr, vecs[i].exp_last);
         chk($sformatf("v%0d_frame_done", i), done_cnt, vecs[i].exp_done);
         chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
         chk($sformatf("v%0d_data_bad", i), data_bad, 0);
         chk($sformatf("v%0d_adr_bad", i), adr_bad, 0);
         chk($sformatf("v%0d_busy_end", i), busy, 0);
         if (vecs[i].exp_done != 0) begin
            chk($sformatf("v%0d_done_adr", i), done_adr, vecs[i].exp_last);
            chk($sformatf("v%0d_done_with_wr", i), done_wren, 1);
            chk($sformatf("v%0d_busy_at_done", i), busy_at_done, 1);
            chk($sformatf("v%0d_busy_after", i), busy_after, 0);
            chk($sformatf("v%0d_latency", i), first_wr_cyc - pix00_cyc, 2);
         end
      end

      // Asynchronous reset in the middle of a capture.
      wait_pos(7, 0);
      cap_req = 1;
      gen_cycle();
      wait_pos(4, 9);
      gen_cycle();
      chk("pre_rst_wr_en", wr_en, 1);
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1;
      #1 chk("rst_mid_outputs", {wr_en, busy, frame_done, err, locked, wr_adr, wr_dat}, 0);
      @(posedge Xclk);
      #1 rst = 0;
      clear_stats();
      repeat (2 * FRAME) gen_cycle();
      chk("post_rst_writes", nwr, 0);
      chk("post_rst_done", done_cnt, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_err", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive side of the 640x480@60 VGA link. Takes hsync/vsync plus RGB444, recovers pixel position from sync edges and writes one captured frame into the frame RAM.
- Sits between an external or looped-back VGA source and RAM_pantalla-style storage.
- Armed by software; reports lock, frame completion and timing errors.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- HPIXELS, 800, total clocks per line, used for the lock check
- HPULSE, 96, hsync pulse width in clocks
- HBP, 48, horizontal back porch
- VPULSE, 2, vsync pulse width in lines
- VBP, 33, vertical back porch
- SYNC_ACTIVE, 1, sync assertion level (1 = active-high)
- ADDR_W, 19, write address width

Ports:
- Xclk  in  1  pixel clock, 25 MHz
- rst  in  1  reset, asynchronous, active-high
- cap_start  in  1  one-cycle pulse; arms a single-frame capture
- hsync_i  in  1  horizontal sync, synchronous to Xclk
- vsync_i  in  1  vertical sync, synchronous to Xclk
- red_i  in  4  red sample
- green_i  in  4  green sample
- blue_i  in  4  blue sample
- wr_en  out  1  RAM write strobe
- wr_adr  out  ADDR_W  RAM write address
- wr_dat  out  12  {red,green,blue}
- busy  out  1  capture in progress (ARMED or CAPTURE)
- frame_done  out  1  one-cycle pulse when the last pixel is written
- locked  out  1  line timing matches HPIXELS
- err  out  1  sticky timing error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Input stage: sync and RGB registered once. Leading edge = registered sample at SYNC_ACTIVE while the previous sample was not.
- hc: cleared to 0 on the cycle the hsync leading edge is detected, otherwise increments, saturating at 1023.
- vc: cleared to 0 on the vsync leading edge, otherwise incremented on the hsync leading edge. If both edges occur in the same cycle, vsync wins (vc=0).
- Active window: x = hc-(HPULSE+HBP), y = vc-(VPULSE+VBP). A pixel is active when 0<=x<H_ACTIVE and 0<=y<V_ACTIVE.
- Lock: on each hsync edge, compare the hc value before clearing against HPIXELS-1.
  - 2 consecutive matches set locked.
  - Any mismatch clears locked and resets the match count.
- FSM:
  - IDLE: cap_start moves to ARMED and clears err. wr_adr is cleared to 0.
  - ARMED: waits for a vsync leading edge while locked=1, then moves to CAPTURE. cap_start here is ignored.
  - CAPTURE: on each active pixel, wr_en=1, wr_dat=sample, and wr_adr increments after each write.
    - After the write of x=H_ACTIVE-1, y=V_ACTIVE-1: frame_done pulses on the same cycle as that final wr_en, then go to IDLE.
    - If locked falls, or a vsync edge arrives before the frame completes: err=1, wr_en=0, go to IDLE. No frame_done.
- Latency: a pixel present at the input on cycle n is written at n+2 (input register plus output register). wr_en, wr_adr and wr_dat are all registered.
- No backpressure: the RAM must accept one write per cycle.
- Async reset mid-capture: immediate return to IDLE, outputs 0, err cleared.
- cap_start in the same cycle as rst: rst wins.

Optional Feature:
- Macro: VGA_CAPTURE_DECIMATE_EN.
- Defined: 2x2 decimation. Only even x and even y are written, giving a 320x240 frame at addresses 0..76799. frame_done is asserted on the write of x=638, y=478.
- Undefined: full-resolution capture at addresses 0..307199.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants (H_ACTIVE, HPIXELS, HPULSE, HBP, V_ACTIVE, VLINES, VPULSE, VBP)
  - RGB444 pixel width
  - FSM state encoding (IDLE, ARMED, CAPTURE)
- One natural sub-module: vga_sync_tracker. It contains the input register, edge detect, hc/vc counters and lock logic, and outputs x, y, active, locked and vsync_edge. The top level keeps the FSM and the write port.

Test Plan:
- Reset, then 3 nominal frames from a reference generator without cap_start: locked=1 by the 3rd line, wr_en never asserts, err=0.
- cap_start mid-frame with a locked source:
  - first wr_en comes 2 cycles after pixel (0,0) of the next frame, with wr_adr=0;
  - exactly 307200 writes;
  - last write at wr_adr=307199 with frame_done pulsing simultaneously;
  - busy falls the next cycle.
- Source pixel = {x[3:0], y[3:0], 4'h5}: each written wr_dat matches the value for address x+640*y.
- During capture, shorten one line to 799 clocks: locked falls, err=1, wr_en stops, no frame_done. The next cap_start clears err.
- Assert rst for 1 cycle at pixel (100,200) of a capture: all outputs 0 the same cycle, FSM returns to IDLE, no further writes.
- With VGA_CAPTURE_DECIMATE_EN: 76800 writes, last at wr_adr=76799, wr_dat taken from source pixel (638,478).
